// File: rtl/rf_multiport.sv
// Multi-port register file with PC alias at the top address, link write and a load scoreboard.
// Optional RF_BYPASS_EN forwards same-cycle writes to the read ports and masks stalls on returning loads.
module rf_multiport #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int NUM_RD  = 3,
  parameter int LR_ADDR = (2 ** ADDR_W) - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wa_en,
  input  logic [ADDR_W-1:0]          wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       link,
  input  logic [DATA_W-1:0]          pc_content,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic                       pc_write,
  output logic [DATA_W-1:0]          pc_wdata,
  output logic                       stall,
  output logic [ADDR_W:0]            pend_cnt,
  output logic                       rsv_err
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] LR_IDX  = ADDR_W'(LR_ADDR);

  logic [DATA_W-1:0] regs [NREGS-1];
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_next;
  logic [CNT_W-1:0]  pend_cnt_next;
  logic              rsv_valid;
  logic              a_hits_pc;
  logic              b_hits_pc;
  logic [NUM_RD-1:0] stall_vec;

  // Only addresses below the PC alias have storage; link beats port A beats port B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS - 1; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS - 1; r++) begin
        if (link && (LR_IDX == ADDR_W'(r))) begin
          regs[r] <= pc_content;
        end else if (wa_en && (wa_addr == ADDR_W'(r))) begin
          regs[r] <= wa_data;
        end else if (wb_en && (wb_addr == ADDR_W'(r))) begin
          regs[r] <= wb_data;
        end
      end
    end
  end

  assign rsv_valid = rsv_en && (rsv_addr != PC_ADDR);

  // A reservation applied after the load-return clear lets a new load win on the same register.
  always_comb begin
    pending_next = pending;
    if (wb_en) begin
      pending_next[wb_addr] = 1'b0;
    end
    if (rsv_valid) begin
      pending_next[rsv_addr] = 1'b1;
    end
    pending_next[PC_ADDR] = 1'b0;
    pend_cnt_next = '0;
    for (int r = 0; r < NREGS; r++) begin
      pend_cnt_next = pend_cnt_next + CNT_W'(pending_next[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
      rsv_err  <= 1'b0;
    end else begin
      pending  <= pending_next;
      pend_cnt <= pend_cnt_next;
      if (rsv_valid && pending[rsv_addr]) begin
        rsv_err <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] value;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    // Bypass overrides are applied lowest priority first; the PC alias always wins.
    always_comb begin
      value = '0;
      for (int r = 0; r < NREGS - 1; r++) begin
        if (addr == ADDR_W'(r)) begin
          value = regs[r];
        end
      end
`ifdef RF_BYPASS_EN
      if (wb_en && (wb_addr == addr)) begin
        value = wb_data;
      end
      if (wa_en && (wa_addr == addr)) begin
        value = wa_data;
      end
      if (link && (LR_IDX == addr)) begin
        value = pc_content;
      end
`endif
      if (addr == PC_ADDR) begin
        value = pc_content;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = value;

`ifdef RF_BYPASS_EN
    assign stall_vec[i] = rd_en[i] && pending[addr] && !(wb_en && (wb_addr == addr));
`else
    assign stall_vec[i] = rd_en[i] && pending[addr];
`endif
  end

  assign stall = |stall_vec;

  assign a_hits_pc = wa_en && (wa_addr == PC_ADDR);
  assign b_hits_pc = wb_en && (wb_addr == PC_ADDR);
  assign pc_write  = a_hits_pc || b_hits_pc;
  assign pc_wdata  = a_hits_pc ? wa_data : (b_hits_pc ? wb_data : '0);

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: stimulus queues expectations, a negedge monitor compares them.
module tb_rf_multiport;

  localparam int S_RD0   = 0;
  localparam int S_RD1   = 1;
  localparam int S_RD2   = 2;
  localparam int S_STALL = 3;
  localparam int S_PCW   = 4;
  localparam int S_PCWD  = 5;
  localparam int S_CNT   = 6;
  localparam int S_ERR   = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  rd_en;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic        wa_en;
  logic [3:0]  wa_addr;
  logic [31:0] wa_data;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        link;
  logic [31:0] pc_content;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        pc_write;
  logic [31:0] pc_wdata;
  logic        stall;
  logic [4:0]  pend_cnt;
  logic        rsv_err;

  exp_t sb[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  rf_multiport dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wa_en      (wa_en),
    .wa_addr    (wa_addr),
    .wa_data    (wa_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .link       (link),
    .pc_content (pc_content),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .pc_write   (pc_write),
    .pc_wdata   (pc_wdata),
    .stall      (stall),
    .pend_cnt   (pend_cnt),
    .rsv_err    (rsv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge and return all strobes to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rd_en   = '0;
    rd_addr = '0;
    wa_en   = 1'b0;
    wa_addr = '0;
    wa_data = '0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    link    = 1'b0;
    rsv_en  = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic setRead(input int p, input logic [3:0] a, input logic en);
    rd_addr[p*4 +: 4] = a;
    rd_en[p]          = en;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Monitor: every falling edge drains the expectations queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        S_RD0:   act = rd_data[31:0];
        S_RD1:   act = rd_data[63:32];
        S_RD2:   act = rd_data[95:64];
        S_STALL: act = {31'd0, stall};
        S_PCW:   act = {31'd0, pc_write};
        S_PCWD:  act = pc_wdata;
        S_CNT:   act = {27'd0, pend_cnt};
        default: act = {31'd0, rsv_err};
      endcase
      check_cnt++;
      if (act === e.exp) begin
        pass_cnt++;
      end else begin
        $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    pc_content = 32'h100;
    rd_en      = '0;
    rd_addr    = '0;
    wa_en      = 1'b0;
    wa_addr    = '0;
    wa_data    = '0;
    wb_en      = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    link       = 1'b0;
    rsv_en     = 1'b0;
    rsv_addr   = '0;
    checkOutput("reset_pend_cnt", S_CNT, 32'd0);
    checkOutput("reset_rsv_err", S_ERR, 32'd0);
    checkOutput("reset_stall", S_STALL, 32'd0);
    checkOutput("reset_pc_write", S_PCW, 32'd0);
    checkOutput("reset_pc_wdata", S_PCWD, 32'd0);

    applyStimulus();
    rst = 1'b0;

    // Every address reads zero except the PC alias.
    for (int a = 0; a < 16; a += 3) begin
      applyStimulus();
      for (int p = 0; p < 3; p++) begin
        int ad;
        ad = (a + p > 15) ? 15 : a + p;
        setRead(p, 4'(ad), 1'b1);
        checkOutput($sformatf("reset_read_r%0d", ad), p, (ad == 15) ? 32'h100 : 32'd0);
      end
      checkOutput("reset_read_stall", S_STALL, 32'd0);
      checkOutput("reset_read_cnt", S_CNT, 32'd0);
    end

    // Port A and port B hit R3 on the same edge.
    applyStimulus();
    wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'hDEADBEEF;
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'h11;
    setRead(0, 4'd3, 1'b0);
`ifdef RF_BYPASS_EN
    checkOutput("ab_same_cycle_r3", S_RD0, 32'hDEADBEEF);
`else
    checkOutput("ab_same_cycle_r3", S_RD0, 32'd0);
`endif
    checkOutput("ab_no_pc_write", S_PCW, 32'd0);

    // Link beats port A on R14.
    applyStimulus();
    link = 1'b1;
    wa_en = 1'b1; wa_addr = 4'd14; wa_data = 32'h55;
    setRead(0, 4'd3, 1'b0);
    setRead(1, 4'd14, 1'b0);
    checkOutput("a_wins_r3", S_RD0, 32'hDEADBEEF);
`ifdef RF_BYPASS_EN
    checkOutput("link_same_cycle_r14", S_RD1, 32'h100);
`else
    checkOutput("link_same_cycle_r14", S_RD1, 32'd0);
`endif

    // Port A targets the PC alias: forwarded out, not stored.
    applyStimulus();
    pc_content = 32'h104;
    wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'h2000;
    setRead(0, 4'd3, 1'b0);
    setRead(1, 4'd14, 1'b0);
    setRead(2, 4'd15, 1'b0);
    checkOutput("link_r14", S_RD1, 32'h100);
    checkOutput("a_pc_write", S_PCW, 32'd1);
    checkOutput("a_pc_wdata", S_PCWD, 32'h2000);
    checkOutput("pc_alias_read", S_RD2, 32'h104);

    applyStimulus();
    wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'h3000;
    setRead(0, 4'd3, 1'b0);
    setRead(1, 4'd14, 1'b0);
    checkOutput("pc_write_no_r3_change", S_RD0, 32'hDEADBEEF);
    checkOutput("pc_write_no_r14_change", S_RD1, 32'h100);
    checkOutput("b_pc_write", S_PCW, 32'd1);
    checkOutput("b_pc_wdata", S_PCWD, 32'h3000);

    applyStimulus();
    wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'h2222;
    wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'h3333;
    checkOutput("ab_pc_wdata_a_wins", S_PCWD, 32'h2222);

    // Reserve R5; a same-cycle read must not stall.
    applyStimulus();
    rsv_en = 1'b1; rsv_addr = 4'd5;
    setRead(0, 4'd5, 1'b1);
    checkOutput("rsv_same_cycle_stall", S_STALL, 32'd0);
    checkOutput("rsv_same_cycle_cnt", S_CNT, 32'd0);

    applyStimulus();
    setRead(0, 4'd5, 1'b1);
    checkOutput("r5_pending_stall", S_STALL, 32'd1);
    checkOutput("r5_pending_cnt", S_CNT, 32'd1);

    applyStimulus();
    setRead(0, 4'd5, 1'b0);
    checkOutput("r5_disabled_read_stall", S_STALL, 32'd0);

    applyStimulus();
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h42;
    setRead(0, 4'd5, 1'b1);
`ifdef RF_BYPASS_EN
    checkOutput("r5_return_stall", S_STALL, 32'd0);
    checkOutput("r5_return_data", S_RD0, 32'h42);
`else
    checkOutput("r5_return_stall", S_STALL, 32'd1);
    checkOutput("r5_return_data", S_RD0, 32'd0);
`endif
    checkOutput("r5_return_cnt", S_CNT, 32'd1);

    applyStimulus();
    setRead(0, 4'd5, 1'b1);
    checkOutput("r5_after_stall", S_STALL, 32'd0);
    checkOutput("r5_after_data", S_RD0, 32'h42);
    checkOutput("r5_after_cnt", S_CNT, 32'd0);

    // Set and clear of R7 on one edge: the reservation wins.
    applyStimulus();
    rsv_en = 1'b1; rsv_addr = 4'd7;
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h77;
    checkOutput("r7_setclr_err", S_ERR, 32'd0);

    applyStimulus();
    rsv_en = 1'b1; rsv_addr = 4'd7;
    setRead(1, 4'd7, 1'b1);
    checkOutput("r7_pending_stall", S_STALL, 32'd1);
    checkOutput("r7_pending_cnt", S_CNT, 32'd1);
    checkOutput("r7_written_data", S_RD1, 32'h77);
    checkOutput("r7_before_err", S_ERR, 32'd0);

    applyStimulus();
    rsv_en = 1'b1; rsv_addr = 4'd15;
    checkOutput("double_rsv_err", S_ERR, 32'd1);
    checkOutput("double_rsv_cnt", S_CNT, 32'd1);
    checkOutput("idle_no_stall", S_STALL, 32'd0);

    applyStimulus();
    rsv_en = 1'b1; rsv_addr = 4'd1;
    checkOutput("pc_rsv_ignored_cnt", S_CNT, 32'd1);
    checkOutput("err_sticky", S_ERR, 32'd1);

    applyStimulus();
    rsv_en = 1'b1; rsv_addr = 4'd2;
    checkOutput("rsv_r1_cnt", S_CNT, 32'd2);

    applyStimulus();
    rsv_en = 1'b1; rsv_addr = 4'd4;
    checkOutput("rsv_r2_cnt", S_CNT, 32'd3);

    applyStimulus();
    setRead(0, 4'd1, 1'b1);
    checkOutput("pre_reset_stall", S_STALL, 32'd1);
    checkOutput("pre_reset_cnt", S_CNT, 32'd4);

    // Asynchronous reset in the middle of outstanding loads.
    applyStimulus();
    rst = 1'b1;
    setRead(0, 4'd1, 1'b1);
    setRead(1, 4'd7, 1'b1);
    setRead(2, 4'd15, 1'b1);
    checkOutput("mid_reset_cnt", S_CNT, 32'd0);
    checkOutput("mid_reset_stall", S_STALL, 32'd0);
    checkOutput("mid_reset_err", S_ERR, 32'd0);
    checkOutput("mid_reset_r7", S_RD1, 32'd0);
    checkOutput("mid_reset_pc", S_RD2, 32'h104);

    applyStimulus();
    rst = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h99;

    applyStimulus();
    setRead(0, 4'd2, 1'b1);
    checkOutput("post_reset_wb_r2", S_RD0, 32'h99);
    checkOutput("post_reset_stall", S_STALL, 32'd0);
    checkOutput("post_reset_cnt", S_CNT, 32'd0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      check_cnt++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised register file for the CPU core, successor to the 15-register/PC-alias file. Provides NUM_RD read ports, two write ports (ALU port A, load-return port B), a link write, the PC visible at the top address, and a per-register load scoreboard that raises a stall when a read source awaits an outstanding load. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- DATA_W, 32, register and PC width
- ADDR_W, 4, address width; NREGS = 2**ADDR_W; address NREGS-1 is the PC alias
- NUM_RD, 3, number of read ports (1..4)
- LR_ADDR, NREGS-2, link register index
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_en  in  NUM_RD  per-port read valid (scoreboard check only)
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- wa_en / wa_addr / wa_data  in  1 / ADDR_W / DATA_W  port A write
- wb_en / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  port B write (load return; clears pending)
- link  in  1  write pc_content into LR_ADDR
- pc_content  in  DATA_W  current PC
- rsv_en / rsv_addr  in  1 / ADDR_W  reserve destination of an issued load
- pc_write  out  1  a write port targets the PC address this cycle
- pc_wdata  out  DATA_W  data for that PC write
- stall  out  1  enabled read port hits a pending register
- pend_cnt  out  ADDR_W+1  number of pending registers
- rsv_err  out  1  sticky: reservation of an already-pending register

## Operation
- Storage: NREGS-1 registers of DATA_W; no storage at PC address.
- Reads combinational; address NREGS-1 returns pc_content.
- Write priority per register on same edge: link > port A > port B.
- Writes to PC address are not stored: pc_write = (wa_en & wa_addr==PC) | (wb_en & wb_addr==PC); pc_wdata = port A data if A hits PC, else port B data; 0 when pc_write low.
- Scoreboard pending[NREGS-1:0], bit for PC address tied 0.
  - rsv_en sets pending[rsv_addr]; wb_en clears pending[wb_addr].
  - Same address set and clear same edge: set wins (new load outstanding).
  - rsv_addr == PC address ignored; rsv_en on already-pending register sets rsv_err (sticky until reset), bit stays 1.
  - port A and link do not affect pending.
- stall = OR over i of rd_en[i] & pending[rd_addr[i]] (subject to bypass, below).
- pend_cnt = popcount(pending), registered with pending.

## Timing
- Reset (async, immediate): all registers 0, pending 0, pend_cnt 0, rsv_err 0; rd_data reflects 0 (PC address still returns pc_content); pc_write 0 unless write inputs request PC.
- Write latency: data visible on rd_data the cycle after the edge (without bypass).
- Reservation visible in stall the cycle after rsv_en edge; a read in the same cycle as rsv_en does not stall on it.
- stall, pc_write, pc_wdata are combinational, no registering.
- Reset asserted mid-operation discards pending loads; a port B write arriving after reset still writes the register.

## Configuration
- RF_BYPASS_EN defined: rd_data for an address being written this cycle returns the write value using link > A > B priority; a pending register with wb_en & wb_addr match this cycle does not contribute to stall.
- Undefined: rd_data always returns stored value; stall uses pending as stored.

## Test plan
- Reset then read all addresses with pc_content=0x100 -> 0 for 0..14, 0x100 at 15; pend_cnt=0.
- Port A write R3=0xDEADBEEF, port B write R3=0x11 same edge -> R3 reads 0xDEADBEEF next cycle; link with wa_addr=14 -> R14 = pc_content.
- wa_addr=15, wa_data=0x2000 -> pc_write=1, pc_wdata=0x2000 same cycle; no register changes.
- rsv R5, next cycle read R5 rd_en=1 -> stall=1, pend_cnt=1; wb R5=0x42 -> with RF_BYPASS_EN stall=0 and rd_data=0x42 that cycle, without stall=1 then 0 next cycle.
- rsv R7 and wb R7 same edge -> pending[7]=1; second rsv R7 -> rsv_err=1 and stays 1.
- Reserve R1,R2,R4 then assert rst mid-sequence -> pend_cnt=0, stall=0, rsv_err=0 immediately.
